cell_histogram: RTL and testbench

CELL_HISTOGRAM -- requirements
Module: cell_histogram

---
 rtl/cell_histogram.sv | 154 +++++++++++++++
 tb/tb_cell_histogram.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cell_histogram.sv
`default_nettype none
// ============================================================================
// Module   : cell_histogram
// Purpose  : Accumulates per-cell orientation histograms from a raster stream
//            of (magnitude, bin) gradient pixels and emits one histogram per
//            CELL_SIZE x CELL_SIZE cell in raster cell order.
// Options  : HIST_SATURATE_EN - accumulator adds saturate instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module cell_histogram #(
    parameter int DATA_WIDTH   = 8,
    parameter int IMAGE_WIDTH  = 640,
    parameter int IMAGE_HEIGHT = 480,
    parameter int CELL_SIZE    = 8,
    parameter int NUM_BINS     = 9,
    parameter int HIST_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           bin_valid,
    output logic                           bin_ready,
    input  logic [DATA_WIDTH-1:0]          magnitude,
    input  logic [3:0]                     bin,
    output logic                           hist_valid,
    input  logic                           hist_ready,
    output logic [NUM_BINS*HIST_WIDTH-1:0] hist,
    output logic                           frame_done
);

    localparam int c_col_w  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int c_row_w  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int c_ncells = IMAGE_WIDTH / CELL_SIZE;
    localparam int c_cell_w = (c_ncells > 1) ? $clog2(c_ncells) : 1;

    logic [c_col_w-1:0]    r_col;
    logic [c_row_w-1:0]    r_row;
    logic [HIST_WIDTH-1:0] r_acc [c_ncells][NUM_BINS];

    logic                  w_accept;
    logic                  w_col_last;
    logic                  w_row_last;
    logic [31:0]           w_col32;
    logic [31:0]           w_row32;
    logic [c_cell_w-1:0]   w_cell;
    logic                  w_cell_done;
    logic                  w_bin_ok;
    logic [HIST_WIDTH-1:0] w_old;
    logic [HIST_WIDTH-1:0] w_added;
    logic [HIST_WIDTH-1:0] w_cell_hist [NUM_BINS];

    // The only back-pressure source is an unaccepted pending histogram.
    assign bin_ready  = !hist_valid || hist_ready;
    assign w_accept   = bin_valid && bin_ready;

    assign w_col_last = (r_col == c_col_w'(IMAGE_WIDTH - 1));
    assign w_row_last = (r_row == c_row_w'(IMAGE_HEIGHT - 1));
    assign w_col32    = 32'(r_col);
    assign w_row32    = 32'(r_row);
    assign w_cell     = c_cell_w'(w_col32 / CELL_SIZE);
    assign w_cell_done = ((w_col32 % CELL_SIZE) == (CELL_SIZE - 1)) &&
                         ((w_row32 % CELL_SIZE) == (CELL_SIZE - 1));
    // Out-of-range bin indices still advance the raster position but add nothing.
    assign w_bin_ok   = (32'(bin) < NUM_BINS);

    // Current accumulator word selected by (cell column, bin).
    always_comb begin
        w_old = '0;
        for (int b = 0; b < NUM_BINS; b++) begin
            if (w_bin_ok && (32'(bin) == b)) begin
                w_old = r_acc[w_cell][b];
            end
        end
    end

`ifdef HIST_SATURATE_EN
    localparam int c_sum_w = ((DATA_WIDTH > HIST_WIDTH) ? DATA_WIDTH : HIST_WIDTH) + 1;
    logic [c_sum_w-1:0] w_sum;
    assign w_sum   = c_sum_w'(w_old) + c_sum_w'(magnitude);
    // Clamp to the all-ones bin value on overflow.
    assign w_added = (w_sum > c_sum_w'({HIST_WIDTH{1'b1}})) ? {HIST_WIDTH{1'b1}}
                                                            : HIST_WIDTH'(w_sum);
`else
    // Truncating the magnitude first is equivalent to a modulo-2^HIST_WIDTH add.
    assign w_added = w_old + HIST_WIDTH'(magnitude);
`endif

    // Histogram of the current cell including the pixel being accepted now.
    always_comb begin
        for (int b = 0; b < NUM_BINS; b++) begin
            w_cell_hist[b] = r_acc[w_cell][b];
            if (w_bin_ok && (32'(bin) == b)) begin
                w_cell_hist[b] = w_added;
            end
        end
    end

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // Accumulator store: add the pixel, or clear the cell once it is emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < c_ncells; c++) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    r_acc[c][b] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int b = 0; b < NUM_BINS; b++) begin
                if (w_cell_done) begin
                    r_acc[w_cell][b] <= '0;
                end else if (w_bin_ok && (32'(bin) == b)) begin
                    r_acc[w_cell][b] <= w_added;
                end
            end
        end
    end

    // Output histogram register with valid/ready hold and frame-end pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist       <= '0;
            hist_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (hist_valid && hist_ready) begin
                hist_valid <= 1'b0;
            end
            // A completing cell overrides the handshake clear above.
            if (w_accept && w_cell_done) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    hist[b*HIST_WIDTH +: HIST_WIDTH] <= w_cell_hist[b];
                end
                hist_valid <= 1'b1;
                frame_done <= w_col_last && w_row_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cell_histogram.sv
`default_nettype none
// ============================================================================
// Module   : tb_cell_histogram
// Purpose  : Directed self-checking bench for cell_histogram on a 16x16 image
//            with 8x8 cells (four cells per frame).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cell_histogram;

    localparam int HW  = 16;
    localparam int NB  = 9;
    localparam int HWN = 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                bin_valid = 1'b0;
    logic                bin_ready;
    logic [7:0]          magnitude = '0;
    logic [3:0]          bin = '0;
    logic                hist_valid;
    logic                hist_ready = 1'b1;
    logic [NB*HW-1:0]    hist;
    logic                frame_done;

    logic                bin_ready8;
    logic                hist_valid8;
    logic [NB*HWN-1:0]   hist8;
    logic                frame_done8;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    logic [NB*HW-1:0]  q   [$];
    logic [NB*HWN-1:0] q8  [$];
    logic              fdq [$];

    always #5 clk = ~clk;

    cell_histogram #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16),
        .CELL_SIZE(8), .NUM_BINS(NB), .HIST_WIDTH(HW)
    ) dut (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .magnitude(magnitude), .bin(bin), .hist_valid(hist_valid),
        .hist_ready(hist_ready), .hist(hist), .frame_done(frame_done)
    );

    // Narrow-bin instance driven identically; used for the overflow case.
    cell_histogram #(
        .DATA_WIDTH(8), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16),
        .CELL_SIZE(8), .NUM_BINS(NB), .HIST_WIDTH(HWN)
    ) dut8 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_ready(bin_ready8),
        .magnitude(magnitude), .bin(bin), .hist_valid(hist_valid8),
        .hist_ready(hist_ready), .hist(hist8), .frame_done(frame_done8)
    );

    // Capture every histogram handshake and every frame_done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (hist_valid && hist_ready) begin
                q.push_back(hist);
                q8.push_back(hist8);
                fdq.push_back(frame_done);
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [NB*HW-1:0] mk(input int b, input int val);
        logic [NB*HW-1:0] v;
        v = '0;
        v[b*HW +: HW] = HW'(val);
        return v;
    endfunction

    task automatic clear_logs();
        q.delete();
        q8.delete();
        fdq.delete();
        fd_cnt = 0;
    endtask

    task automatic send(input logic [7:0] m, input logic [3:0] b);
        int waitc;
        waitc = 0;
        @(negedge clk);
        bin_valid = 1'b1;
        magnitude = m;
        bin       = b;
        while (!bin_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!bin_ready) check_eq("ready_timeout", 160'(bin_ready), 160'(1));
        @(posedge clk);
        #1 bin_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [NB*HW-1:0] exp4;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_hist_valid", 160'(hist_valid), 160'(0));
        check_eq("rst_frame_done", 160'(frame_done), 160'(0));
        check_eq("rst_hist",       160'(hist),       160'(0));
        check_eq("rst_bin_ready",  160'(bin_ready),  160'(1));

        // Uniform frame: magnitude 1 into bin 3
        clear_logs();
        for (int p = 0; p < 256; p++) send(8'd1, 4'd3);
        idle(4);
        check_eq("uni_count", 160'(q.size()), 160'(4));
        for (int i = 0; i < 4 && i < q.size(); i++)
            check_eq($sformatf("uni_hist%0d", i), 160'(q[i]), 160'(mk(3, 64)));
        if (fdq.size() == 4)
            check_eq("uni_fd_pos", 160'({fdq[3], fdq[2], fdq[1], fdq[0]}), 160'(4'b1000));
        check_eq("uni_fd_cnt", 160'(fd_cnt), 160'(1));

        // Single pixel at (0,0), bin 8, magnitude 255
        clear_logs();
        for (int p = 0; p < 256; p++) send((p == 0) ? 8'd255 : 8'd0, (p == 0) ? 4'd8 : 4'd0);
        idle(4);
        check_eq("single_count", 160'(q.size()), 160'(4));
        if (q.size() > 0) check_eq("single_hist0", 160'(q[0]), 160'(mk(8, 255)));
        if (q.size() > 1) check_eq("single_hist1", 160'(q[1]), 160'(0));

        // Back-pressure on the first cell; bin = col%4 exposes any lost pixel
        clear_logs();
        exp4 = mk(0, 16) | mk(1, 16) | mk(2, 16) | mk(3, 16);
        hist_ready = 1'b0;
        fork
            begin
                for (int p = 0; p < 256; p++) send(8'd1, 4'(p % 4));
            end
            begin
                int t;
                t = 0;
                while (!hist_valid && t < 1000) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("stall_seen", 160'(hist_valid), 160'(1));
                repeat (5) @(negedge clk);
                check_eq("stall_bin_ready", 160'(bin_ready), 160'(0));
                check_eq("stall_hist_held", 160'(hist), 160'(exp4));
                check_eq("stall_valid_held", 160'(hist_valid), 160'(1));
                @(posedge clk);
                #1 hist_ready = 1'b1;
            end
        join
        idle(4);
        check_eq("stall_count", 160'(q.size()), 160'(4));
        for (int i = 0; i < 4 && i < q.size(); i++)
            check_eq($sformatf("stall_hist%0d", i), 160'(q[i]), 160'(exp4));
        check_eq("stall_fd_cnt", 160'(fd_cnt), 160'(1));

        // Out-of-range bin: nothing accumulates, cells still emitted
        clear_logs();
        for (int p = 0; p < 256; p++) send(8'd5, 4'd12);
        idle(4);
        check_eq("oob_count", 160'(q.size()), 160'(4));
        for (int i = 0; i < 4 && i < q.size(); i++)
            check_eq($sformatf("oob_hist%0d", i), 160'(q[i]), 160'(0));
        check_eq("oob_fd_cnt", 160'(fd_cnt), 160'(1));

        // Overflow: 64 x 255 into bin 0 of cell 0
        clear_logs();
        for (int p = 0; p < 256; p++)
            send((((p / 16) < 8) && ((p % 16) < 8)) ? 8'd255 : 8'd0, 4'd0);
        idle(4);
        if (q.size() > 0) begin
            check_eq("ovf_hist16", 160'(q[0]), 160'(mk(0, 16320)));
`ifdef HIST_SATURATE_EN
            check_eq("ovf_hist8", 160'(q8[0]), 160'(72'd255));
`else
            check_eq("ovf_hist8", 160'(q8[0]), 160'(72'd192));
`endif
        end else begin
            check_eq("ovf_count", 160'(q.size()), 160'(4));
        end

        // Reset mid-frame, then a clean frame of magnitude 2 into bin 1
        for (int p = 0; p < 100; p++) send(8'd7, 4'd2);
        do_reset();
        clear_logs();
        @(negedge clk);
        check_eq("mid_rst_valid", 160'(hist_valid), 160'(0));
        for (int p = 0; p < 256; p++) send(8'd2, 4'd1);
        idle(4);
        check_eq("rst_frame_count", 160'(q.size()), 160'(4));
        for (int i = 0; i < 4 && i < q.size(); i++)
            check_eq($sformatf("rst_frame_hist%0d", i), 160'(q[i]), 160'(mk(1, 128)));
        check_eq("rst_frame_fd_cnt", 160'(fd_cnt), 160'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
